// File: rtl/fetch_decode_if.sv
// fetch_decode_if: bus bundle between the fetch/decode sequencer and its
// neighbours (instruction ROM, register bank, ALU).
//   master (sequencer): drives imem_addr, addr1, addr2, addrdest, alu_op,
//                       control, halted; receives imem_rdata, status.
//   slave  (system)   : the mirror image.
// Parameter PC_WIDTH sets the instruction-address width.
interface fetch_decode_if #(
  parameter int PC_WIDTH = 8
) ();
  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_rdata;
  logic [3:0]          status;
  logic [3:0]          addr1;
  logic [3:0]          addr2;
  logic [3:0]          addrdest;
  logic [3:0]          alu_op;
  logic                control;
  logic                halted;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  status,
    output addr1,
    output addr2,
    output addrdest,
    output alu_op,
    output control,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output status,
    input  addr1,
    input  addr2,
    input  addrdest,
    input  alu_op,
    input  control,
    input  halted
  );
endinterface

// File: rtl/fetch_decode.sv
// fetch_decode: four-phase instruction sequencer (FETCH, DECODE, EXECUTE,
// WRITEBACK, plus sticky HALT). Fetches 16-bit instructions from a
// synchronous ROM, decodes register addresses / ALU opcode, emits a one-cycle
// register-bank write strobe and keeps the program counter.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-high reset
//   enable - global run enable; low freezes all state and masks control
//   bus    - fetch_decode_if.master (ROM address/data, ALU status, decoded
//            register addresses, alu_op, control strobe, halted flag)
// Build option: define FETCH_DECODE_BRANCH_EN to implement JMP (0xC) and
// BZ (0xD) with the zero flag; otherwise both execute as NOP, there is no
// zero flag and status is ignored.
module fetch_decode #(
  parameter int PC_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fetch_decode_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Opcodes 0x1..0xB go through the ALU and are written back.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'hB);
  endfunction

  // Jump target: 8-bit field truncated or zero-extended to the PC width.
  function automatic logic [PC_WIDTH-1:0] jump_target(input logic [7:0] t);
    logic [PC_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; (i < PC_WIDTH) && (i < 8); i++) begin
      r[i] = t[i];
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q;
  logic [3:0]          alu_op_q;
  logic                control_q;
  logic                halted_q;
  logic [3:0]          op_s;
  logic                take_branch_s;
  logic [PC_WIDTH-1:0] pc_inc_s;
  logic [PC_WIDTH-1:0] target_s;

  assign op_s     = ir_q[15:12];
  assign pc_inc_s = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign target_s = jump_target(ir_q[7:0]);

`ifdef FETCH_DECODE_BRANCH_EN
  logic zflag_q;
  logic status_unused;
  assign status_unused = ^bus.status[3:1];

  // Branch decision from the instruction held in ir and the zero flag.
  always_comb begin
    take_branch_s = 1'b0;
    if (op_s == OP_JMP) begin
      take_branch_s = 1'b1;
    end else if (op_s == OP_BZ) begin
      take_branch_s = zflag_q;
    end else begin
      take_branch_s = 1'b0;
    end
  end
`else
  logic status_unused;
  assign status_unused = ^bus.status;
  assign take_branch_s = 1'b0;
`endif

  // Next-state and next-PC selection; pc only moves at the end of WRITEBACK.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        if (op_s == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = take_branch_s ? target_s : pc_inc_s;
        end
      end
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Sequencer state and registered outputs; enable low freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= 16'h0000;
      alu_op_q  <= 4'h0;
      control_q <= 1'b0;
      halted_q  <= 1'b0;
`ifdef FETCH_DECODE_BRANCH_EN
      zflag_q   <= 1'b0;
`endif
    end else if (enable) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == S_HALT);
      // Strobe is pre-decoded so it is a flop output during WRITEBACK.
      control_q <= (state_d == S_WRITEBACK) && is_alu_op(op_s);
      // ROM data is valid in DECODE (one cycle after the FETCH address).
      if (state_q == S_DECODE) begin
        ir_q     <= bus.imem_rdata;
        alu_op_q <= is_alu_op(bus.imem_rdata[15:12]) ? bus.imem_rdata[15:12] : 4'h0;
      end
`ifdef FETCH_DECODE_BRANCH_EN
      if ((state_q == S_WRITEBACK) && is_alu_op(op_s)) begin
        zflag_q <= bus.status[0];
      end
`endif
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.addr1     = ir_q[7:4];
  assign bus.addr2     = ir_q[3:0];
  assign bus.addrdest  = ir_q[11:8];
  assign bus.alu_op    = alu_op_q;
  // A stall masks the strobe at once; it reappears for the resumed cycle.
  assign bus.control   = control_q & enable;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed self-checking bench for fetch_decode.
// Drives a 256-entry synchronous ROM model and the ALU status bits; expected
// values are hand-computed per scenario (branch expectations follow
// FETCH_DECODE_BRANCH_EN).
module tb_fetch_decode;

`ifdef FETCH_DECODE_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] rom [256];
  int          checks;
  int          failures;

  fetch_decode_if #(.PC_WIDTH(8)) bus ();

  fetch_decode #(.PC_WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction ROM: data valid one cycle after the address.
  always @(posedge clk) begin
    bus.imem_rdata <= rom[bus.imem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Holds reset for two cycles; returns at the negedge where reset drops (FETCH of pc 0).
  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 16'h1321;
    bus.status = 4'h0;
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.imem_addr, bus.addr1, bus.addr2, bus.addrdest, bus.alu_op, bus.control, bus.halted} !== 26'h0) begin
      failures++;
      $display("FAIL reset_outputs act=%h exp=0", {bus.imem_addr, bus.addr1, bus.addr2, bus.addrdest, bus.alu_op, bus.control, bus.halted});
    end
    reset = 1'b0;
    step(3);
    checks++;
    if (bus.control !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_wb_control act=%b exp=1", bus.control);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.control !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_control act=%b exp=0", bus.control);
    end
    checks++;
    if ({bus.imem_addr, bus.addr1, bus.addr2, bus.addrdest, bus.alu_op, bus.halted} !== 25'h0) begin
      failures++;
      $display("FAIL reset_async_outputs act=%h exp=0", {bus.imem_addr, bus.addr1, bus.addr2, bus.addrdest, bus.alu_op, bus.halted});
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_refetch_addr act=%h exp=00", bus.imem_addr);
    end
    step(3);
    checks++;
    if ({bus.control, bus.addrdest} !== {1'b1, 4'h3}) begin
      failures++;
      $display("FAIL reset_rerun_wb act=%h exp=13", {bus.control, bus.addrdest});
    end
  endtask

  task automatic test_alu_seq();
    clear_rom();
    rom[0] = 16'h1321;
    rom[1] = 16'h2403;
    bus.status = 4'h0;
    do_reset();
    step(2);
    checks++;
    if ({bus.addrdest, bus.addr1, bus.addr2, bus.alu_op, bus.control} !== {4'h3, 4'h2, 4'h1, 4'h1, 1'b0}) begin
      failures++;
      $display("FAIL alu1_execute act=%h exp=%h", {bus.addrdest, bus.addr1, bus.addr2, bus.alu_op, bus.control}, {4'h3, 4'h2, 4'h1, 4'h1, 1'b0});
    end
    step(1);
    checks++;
    if ({bus.addrdest, bus.addr1, bus.addr2, bus.alu_op, bus.control} !== {4'h3, 4'h2, 4'h1, 4'h1, 1'b1}) begin
      failures++;
      $display("FAIL alu1_writeback act=%h exp=%h", {bus.addrdest, bus.addr1, bus.addr2, bus.alu_op, bus.control}, {4'h3, 4'h2, 4'h1, 4'h1, 1'b1});
    end
    step(1);
    checks++;
    if ({bus.imem_addr, bus.control} !== {8'h01, 1'b0}) begin
      failures++;
      $display("FAIL alu2_fetch act=%h exp=%h", {bus.imem_addr, bus.control}, {8'h01, 1'b0});
    end
    step(3);
    checks++;
    if ({bus.addrdest, bus.addr1, bus.addr2, bus.alu_op, bus.control} !== {4'h4, 4'h0, 4'h3, 4'h2, 1'b1}) begin
      failures++;
      $display("FAIL alu2_writeback act=%h exp=%h", {bus.addrdest, bus.addr1, bus.addr2, bus.alu_op, bus.control}, {4'h4, 4'h0, 4'h3, 4'h2, 1'b1});
    end
    step(1);
    checks++;
    if ({bus.imem_addr, bus.control} !== {8'h02, 1'b0}) begin
      failures++;
      $display("FAIL alu3_fetch act=%h exp=%h", {bus.imem_addr, bus.control}, {8'h02, 1'b0});
    end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[0] = 16'h1321;
    bus.status = 4'h0;
    do_reset();
    step(3);
    checks++;
    if (bus.control !== 1'b1) begin
      failures++;
      $display("FAIL stall_pre_control act=%b exp=1", bus.control);
    end
    enable = 1'b0;
    #1;
    checks++;
    if (bus.control !== 1'b0) begin
      failures++;
      $display("FAIL stall_mask_control act=%b exp=0", bus.control);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.imem_addr, bus.control} !== {8'h00, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold_%0d act=%h exp=000", k, {bus.imem_addr, bus.control});
      end
    end
    enable = 1'b1;
    #1;
    checks++;
    if ({bus.imem_addr, bus.control} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL stall_resume_pulse act=%h exp=001", {bus.imem_addr, bus.control});
    end
    @(negedge clk);
    checks++;
    if ({bus.imem_addr, bus.control} !== {8'h01, 1'b0}) begin
      failures++;
      $display("FAIL stall_after_pulse act=%h exp=002", {bus.imem_addr, bus.control});
    end
    step(4);
    checks++;
    if (bus.imem_addr !== 8'h02) begin
      failures++;
      $display("FAIL stall_pc_once act=%h exp=02", bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 4; c++) begin
      logic [15:0] i1;
      logic [15:0] i2;
      logic        s0;
      logic        s1;
      int          n;
      logic [7:0]  exp_addr;
      case (c)
        0: begin i1 = 16'hD020; i2 = 16'h0000; s0 = 1'b1; s1 = 1'b1; n = 2; exp_addr = BR ? 8'h20 : 8'h02; end
        1: begin i1 = 16'hD020; i2 = 16'h0000; s0 = 1'b0; s1 = 1'b0; n = 2; exp_addr = 8'h02; end
        2: begin i1 = 16'h0000; i2 = 16'hD040; s0 = 1'b1; s1 = 1'b0; n = 3; exp_addr = BR ? 8'h40 : 8'h03; end
        default: begin i1 = 16'h1321; i2 = 16'hD040; s0 = 1'b1; s1 = 1'b0; n = 3; exp_addr = 8'h03; end
      endcase
      clear_rom();
      rom[0] = 16'h1321;
      rom[1] = i1;
      rom[2] = i2;
      bus.status = s0 ? 4'b0001 : 4'b1110;
      do_reset();
      step(4);
      bus.status = s1 ? 4'b0001 : 4'b1110;
      step(4 * (n - 1));
      checks++;
      if (bus.imem_addr !== exp_addr) begin
        failures++;
        $display("FAIL branch_case%0d act=%h exp=%h", c, bus.imem_addr, exp_addr);
      end
    end
  endtask

  task automatic test_wrap_halt();
    clear_rom();
    rom[0] = 16'hC0FF;
    bus.status = 4'h0;
    do_reset();
    step(4);
    checks++;
    if (bus.imem_addr !== (BR ? 8'hFF : 8'h01)) begin
      failures++;
      $display("FAIL wrap_jmp_target act=%h exp=%h", bus.imem_addr, (BR ? 8'hFF : 8'h01));
    end
    rom[0] = 16'hF000;
    step(BR ? 4 : 4 * 255);
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL wrap_pc act=%h exp=00", bus.imem_addr);
    end
    step(3);
    checks++;
    if ({bus.control, bus.halted} !== 2'b00) begin
      failures++;
      $display("FAIL halt_writeback act=%b exp=00", {bus.control, bus.halted});
    end
    step(1);
    checks++;
    if ({bus.imem_addr, bus.halted} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL halt_entered act=%h exp=001", {bus.imem_addr, bus.halted});
    end
    for (int k = 0; k < 20; k++) begin
      step(1);
      checks++;
      if ({bus.imem_addr, bus.control, bus.halted} !== {8'h00, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL halt_sticky_%0d act=%h exp=001", k, {bus.imem_addr, bus.control, bus.halted});
      end
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    bus.status = 4'h0;
    test_reset();
    test_alu_seq();
    test_stall();
    test_branch();
    test_wrap_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction sequencer that sits directly upstream of the register bank and ALU inside `processor`. It fetches 16-bit instructions from a synchronous instruction ROM and decodes them into register-bank addresses, the ALU operation code and the register-bank write strobe. It also maintains the program counter and handles jumps and halting.

## Interface
- `PC_WIDTH`, 8, program counter and instruction-address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  global run enable, the same net that feeds regbank and alu; low = stall.
- `imem_addr`  out  PC_WIDTH  instruction ROM address; always equals `pc`.
- `imem_rdata`  in  16  ROM data, valid one cycle after `imem_addr`.
- `status`  in  4  ALU status; bit 0 = result zero.
- `addr1`, `addr2`  out  4  regbank read addresses; `addr1` = ir[7:4], `addr2` = ir[3:0].
- `addrdest`  out  4  regbank write address; ir[11:8].
- `alu_op`  out  4  ALU operation; ir[15:12] for ALU opcodes, else 0.
- `control`  out  1  regbank write strobe, one cycle wide.
- `halted`  out  1  high once HALT has executed.

## Operation
- Instruction format: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2. For jumps, [7:0] is the target and is truncated/zero-extended to PC_WIDTH.
- Opcode map:
  - 0x0: NOP.
  - 0x1–0xB: ALU operations, written back to `dest`.
  - 0xC: JMP, unconditional.
  - 0xD: BZ, branch if `zflag`=1.
  - 0xE: reserved, executes as NOP.
  - 0xF: HALT.
- FSM states: FETCH → DECODE → EXECUTE → WRITEBACK → FETCH, plus HALT.
  - FETCH: present `pc` on `imem_addr`.
  - DECODE: capture `imem_rdata` into `ir` at the end of the cycle.
  - EXECUTE: `addr1`, `addr2` and `alu_op` are stable from `ir`; the ALU evaluates.
  - WRITEBACK, ALU opcodes: `control`=1 and `zflag` <= `status[0]` at the end of the cycle.
  - WRITEBACK, all opcodes: `pc` updates at the end of the cycle. JMP/taken BZ load the target; all others load `pc`+1.
  - WRITEBACK, HALT opcode: next state is HALT, and `pc` holds.
- HALT is sticky: `halted`=1 and `control`=0 until reset.
- `enable`=0 freezes the state, `pc`, `ir` and `zflag`, and forces `control`=0. Work resumes in the same state when `enable` returns high.
- `pc` wraps from 2^PC_WIDTH−1 to 0 without a flag.
- `zflag` is changed only by ALU opcodes. NOP, jumps and reserved opcodes leave it unchanged.

## Timing
- Reset values: state=FETCH, `pc`=0, `ir`=0, `zflag`=0. Outputs: `imem_addr`=0, `addr1`=`addr2`=`addrdest`=0, `alu_op`=0, `control`=0, `halted`=0.
- Reset is asynchronous. Asserting it mid-instruction forces the reset values immediately, and no write strobe is emitted.
- Once `reset` deasserts, FETCH begins on the next rising edge.
- Throughput is one instruction per 4 enabled cycles. An ALU result is written on the 4th cycle after its FETCH.
- `control` is a registered decode of state==WRITEBACK, gated combinationally by `enable`. It never lasts longer than one enabled cycle per instruction.
- Jump targets take effect at the next FETCH. There is no branch delay slot.
- Address outputs change only at the DECODE→EXECUTE edge and stay stable through WRITEBACK.

## Configuration
- `FETCH_DECODE_BRANCH_EN` defined: JMP and BZ are implemented as described above.
- Not defined:
  - 0xC and 0xD execute as NOP, and `pc` always increments.
  - `zflag` is not implemented and `status` is ignored.
  - Everything else is unchanged.

## Test plan
- Reset/idle: assert `reset` mid-WRITEBACK of an ALU op. Required: `control` drops at once, all outputs return to 0, and the next fetch is from address 0.
- ALU sequence: ROM[0]=0x1321, ROM[1]=0x2403. Required:
  - `addrdest`=3, `addr1`=2, `addr2`=1 and `alu_op`=1 with `control` pulsed in cycle 4.
  - Then `addrdest`=4, `addr1`=0, `addr2`=3 and `alu_op`=2 with `control` pulsed in cycle 8.
- Stall: drop `enable` for 3 cycles during WRITEBACK. Required: `control` stays 0 while stalled, then a single pulse after resume, and `pc` advances exactly once.
- Branch (with macro):
  - ROM[0] is an ALU op returning `status[0]`=1, ROM[1]=0xD020. Required: the next `imem_addr` is 0x20.
  - Repeat with `status[0]`=0. Required: the next `imem_addr` is 2.
  - Without the macro, both cases fetch address 2.
- Wrap and halt: JMP 0xFF, then ROM[0xFF]=NOP and ROM[0]=0xF000. Required:
  - `pc` wraps to 0.
  - `halted`=1 after HALT's WRITEBACK.
  - `imem_addr` stays 0, and `control` stays 0 for 20 further cycles.
